slow_mem_responder: RTL and testbench

- Synthesizable memory-side responder for the cache refill/write-back interface: receives 128-bit line reads/writes from a cache miss engine and answers after a programmable latency with a one-cycle mem_ready pulse.
- One instance serves the D cache (mem_*_D) and one serves the I cache (mem_*_I) in FPGA/emulation builds, replacing the behavioural slow memory.
- Also provides a backdoor preload port for instruction/data images and sticky protocol-error reporting.

---
 rtl/slow_mem_pkg.sv | 21 ++
 rtl/slow_mem_responder_if.sv | 36 +++
 rtl/mem_line_array.sv | 26 ++
 rtl/slow_mem_responder.sv | 152 +++++++++++++++
 tb/tb_slow_mem_responder.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/slow_mem_pkg.sv
// Shared definitions for the slow memory responder.
// Holds the line/address widths, the responder FSM state type and the
// latched-operation encoding used by the top level.
package slow_mem_pkg;

  localparam int unsigned LINE_W = 128;
  localparam int unsigned ADDR_W = 28;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp,
    StCool
  } state_e;

  typedef enum logic {
    OpRd = 1'b0,
    OpWr = 1'b1
  } op_e;

endpackage

// File: rtl/slow_mem_responder_if.sv
// Cache refill/write-back bus between a cache miss engine and memory.
//   mem_read/mem_write : request, held by the cache until mem_ready
//   mem_addr           : line address (byte address bits 31:4)
//   mem_wdata          : write line data
//   mem_rdata          : read line data, valid only while mem_ready=1
//   mem_ready          : one-cycle completion pulse
// master = cache side, slave = memory side.
interface slow_mem_responder_if;
  import slow_mem_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_read,
    output mem_write,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/mem_line_array.sv
// Line storage: one write port, one synchronous read port, no reset.
//   clk   : clock
//   wen   : write enable, waddr/wdata written at the clock edge
//   raddr : read index, rdata holds the line one cycle later
module mem_line_array #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned WIDTH      = 128
) (
  input  logic                  clk,
  input  logic                  wen,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] lines [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wen) begin
      lines[waddr] <= wdata;
    end
    rdata <= lines[raddr];
  end

endmodule

// File: rtl/slow_mem_responder.sv
// Memory-side responder for the cache line interface. Accepts one line
// read/write, answers LATENCY cycles later with a one-cycle mem_ready, then
// idles one cycle before the next acceptance.
//   clk, proc_reset : clock, synchronous active-high reset
//   mem             : cache bus (slave side)
//   init_*          : backdoor line preload, honoured only when idle
//   rd_count/wr_count : saturating completed-transfer counters
//   protocol_err    : sticky, cleared only by proc_reset
module slow_mem_responder
  import slow_mem_pkg::*;
#(
  parameter int unsigned LATENCY    = 8,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  proc_reset,
  slow_mem_responder_if.slave   mem,
  input  logic                  init_wen,
  input  logic [DEPTH_LOG2-1:0] init_addr,
  input  logic [LINE_W-1:0]     init_wdata,
  output logic [CNT_W-1:0]      rd_count,
  output logic [CNT_W-1:0]      wr_count,
  output logic                  protocol_err
);

  localparam logic [7:0] CntInit = 8'(LATENCY - 1);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  op_e                   op_q, op_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]     wdata_q, wdata_d;
  logic [CNT_W-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic                  err_q, err_d;

  logic                  arr_wen;
  logic [DEPTH_LOG2-1:0] arr_waddr, arr_raddr;
  logic [LINE_W-1:0]     arr_wdata, arr_rdata;
  logic                  req;
  logic                  unused_addr;

  // Upper line-address bits are dropped so accesses wrap.
  assign unused_addr = ^mem.mem_addr[ADDR_W-1:DEPTH_LOG2];
  assign req         = mem.mem_read | mem.mem_write;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    err_d     = err_q;
    arr_wen   = 1'b0;
    arr_waddr = addr_q;
    arr_wdata = wdata_q;
    arr_raddr = addr_q;

    unique case (state_q)
      StIdle: begin
        // Read the incoming index now so the line is ready for LATENCY=1.
        arr_raddr = mem.mem_addr[DEPTH_LOG2-1:0];
        if (req) begin
          op_d    = mem.mem_write ? OpWr : OpRd;
          addr_d  = mem.mem_addr[DEPTH_LOG2-1:0];
          wdata_d = mem.mem_wdata;
          cnt_d   = CntInit;
          state_d = (LATENCY == 1) ? StResp : StBusy;
          if ((mem.mem_read && mem.mem_write) || init_wen) begin
            err_d = 1'b1;
          end
        end else if (init_wen) begin
          arr_wen   = 1'b1;
          arr_waddr = init_addr;
          arr_wdata = init_wdata;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StCool;
        if (op_q == OpWr) begin
          arr_wen = 1'b1;
          if (wr_q != '1) wr_d = wr_q + CNT_W'(1);
        end else begin
          if (rd_q != '1) rd_d = rd_q + CNT_W'(1);
        end
      end
      StCool: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (init_wen && (state_q != StIdle)) begin
      err_d = 1'b1;
    end
    // A reset in RESP must not commit the pending write.
    if (proc_reset) begin
      arr_wen = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpRd;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  mem_line_array #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (LINE_W)
  ) u_array (
    .clk  (clk),
    .wen  (arr_wen),
    .waddr(arr_waddr),
    .wdata(arr_wdata),
    .raddr(arr_raddr),
    .rdata(arr_rdata)
  );

  assign mem.mem_ready = (state_q == StResp);
  assign mem.mem_rdata = ((state_q == StResp) && (op_q == OpRd)) ? arr_rdata : '0;
  assign rd_count      = rd_q;
  assign wr_count      = wr_q;
  assign protocol_err  = err_q;

endmodule

// File: tb/tb_slow_mem_responder.sv
// Randomized bench for slow_mem_responder: two instances (LATENCY=5 and
// LATENCY=1) with a small array and 4-bit counters, checked every cycle
// against a transaction-timing reference model.
module tb_slow_mem_responder;
  import slow_mem_pkg::*;

  localparam int unsigned DL   = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned NL   = 1 << DL;
  localparam int          LAT0 = 5;
  localparam int          LAT1 = 1;
  localparam int          SAT  = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst   [2];
  logic              rd    [2];
  logic              wr    [2];
  logic [ADDR_W-1:0] ad    [2];
  logic [LINE_W-1:0] wd    [2];
  logic              iw    [2];
  logic [DL-1:0]     ia    [2];
  logic [LINE_W-1:0] idat  [2];
  logic [CW-1:0]     rdc_o [2];
  logic [CW-1:0]     wrc_o [2];
  logic              err_o [2];
  logic              rdy_o [2];
  logic [LINE_W-1:0] rdat_o[2];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state
  bit                m_pend[2];
  int                m_due [2];
  int                m_free[2];
  bit                m_wr  [2];
  int                m_addr[2];
  logic [LINE_W-1:0] m_wd  [2];
  logic [LINE_W-1:0] m_mem [2][NL];
  int                m_rdc [2];
  int                m_wrc [2];
  bit                m_err [2];
  bit                act   [2];

  always #5 clk = ~clk;

  slow_mem_responder_if if0 ();
  slow_mem_responder_if if1 ();

  assign if0.mem_read  = rd[0];
  assign if0.mem_write = wr[0];
  assign if0.mem_addr  = ad[0];
  assign if0.mem_wdata = wd[0];
  assign if1.mem_read  = rd[1];
  assign if1.mem_write = wr[1];
  assign if1.mem_addr  = ad[1];
  assign if1.mem_wdata = wd[1];
  assign rdy_o[0]  = if0.mem_ready;
  assign rdy_o[1]  = if1.mem_ready;
  assign rdat_o[0] = if0.mem_rdata;
  assign rdat_o[1] = if1.mem_rdata;

  slow_mem_responder #(.LATENCY(LAT0), .DEPTH_LOG2(DL), .CNT_W(CW)) dut0 (
    .clk         (clk),
    .proc_reset  (rst[0]),
    .mem         (if0),
    .init_wen    (iw[0]),
    .init_addr   (ia[0]),
    .init_wdata  (idat[0]),
    .rd_count    (rdc_o[0]),
    .wr_count    (wrc_o[0]),
    .protocol_err(err_o[0])
  );

  slow_mem_responder #(.LATENCY(LAT1), .DEPTH_LOG2(DL), .CNT_W(CW)) dut1 (
    .clk         (clk),
    .proc_reset  (rst[1]),
    .mem         (if1),
    .init_wen    (iw[1]),
    .init_addr   (ia[1]),
    .init_wdata  (idat[1]),
    .rd_count    (rdc_o[1]),
    .wr_count    (wrc_o[1]),
    .protocol_err(err_o[1])
  );

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                          input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model: an accepted request at cycle t completes in cycle t+lat and the
  // next request may be taken at t+lat+2.
  task automatic model_step(input int k);
    int lat;
    bit idle;
    lat = (k == 0) ? LAT0 : LAT1;
    if (rst[k]) begin
      m_pend[k] = 0;
      m_rdc[k]  = 0;
      m_wrc[k]  = 0;
      m_err[k]  = 0;
      m_free[k] = cyc + 1;
      return;
    end
    if (m_pend[k] && cyc == m_due[k]) begin
      if (m_wr[k]) begin
        m_mem[k][m_addr[k]] = m_wd[k];
        if (m_wrc[k] < SAT) m_wrc[k]++;
      end else if (m_rdc[k] < SAT) begin
        m_rdc[k]++;
      end
      m_pend[k] = 0;
    end
    idle = !m_pend[k] && (cyc >= m_free[k]);
    if (idle && (rd[k] || wr[k])) begin
      m_pend[k] = 1;
      m_due[k]  = cyc + lat;
      m_free[k] = cyc + lat + 2;
      m_wr[k]   = wr[k];
      m_addr[k] = int'(ad[k] % NL);
      m_wd[k]   = wd[k];
      if ((rd[k] && wr[k]) || iw[k]) m_err[k] = 1;
    end else if (iw[k]) begin
      if (idle) m_mem[k][ia[k]] = idat[k];
      else      m_err[k] = 1;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
    cyc++;
  end

  task automatic do_checks(input int k);
    bit                exp_rdy;
    logic [LINE_W-1:0] exp_dat;
    exp_rdy = m_pend[k] && (cyc == m_due[k]);
    exp_dat = (exp_rdy && !m_wr[k]) ? m_mem[k][m_addr[k]] : '0;
    check_eq($sformatf("d%0d.mem_ready", k), LINE_W'(rdy_o[k]), LINE_W'(exp_rdy));
    check_eq($sformatf("d%0d.mem_rdata", k), rdat_o[k], exp_dat);
    check_eq($sformatf("d%0d.rd_count", k), LINE_W'(rdc_o[k]), LINE_W'(m_rdc[k]));
    check_eq($sformatf("d%0d.wr_count", k), LINE_W'(wrc_o[k]), LINE_W'(m_wrc[k]));
    check_eq($sformatf("d%0d.protocol_err", k), LINE_W'(err_o[k]), LINE_W'(m_err[k]));
  endtask

  task automatic new_req(input int k);
    int op;
    op    = $urandom_range(9);
    rd[k] = (op <= 4) || (op == 9);
    wr[k] = (op >= 5);
    ad[k] = ADDR_W'($urandom_range(63));  // wraps past the 16-line array
    wd[k] = rand_line();
    act[k] = 1;
  endtask

  task automatic drive(input int k);
    iw[k] = 0;
    if (rst[k]) begin
      rst[k] = 0;
      return;
    end
    if ($urandom_range(599) == 0) begin
      rst[k] = 1;
      rd[k]  = 0;
      wr[k]  = 0;
      act[k] = 0;
      return;
    end
    if (act[k]) begin
      if (rdy_o[k]) begin
        // Sometimes keep requesting through the cool-down cycle.
        if ($urandom_range(3) != 0) begin
          act[k] = 0;
          rd[k]  = 0;
          wr[k]  = 0;
        end
      end else if ($urandom_range(15) == 0) begin
        ad[k] = ADDR_W'($urandom_range(63));  // must be ignored once latched
        wd[k] = rand_line();
      end
      if (act[k] && $urandom_range(31) == 0) begin
        iw[k]   = 1;
        ia[k]   = DL'($urandom);
        idat[k] = rand_line();
      end
    end else if ($urandom_range(2) == 0) begin
      new_req(k);
    end else if ($urandom_range(5) == 0) begin
      iw[k]   = 1;
      ia[k]   = DL'($urandom);
      idat[k] = rand_line();
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1; rd[k] = 0; wr[k] = 0; ad[k] = '0; wd[k] = '0;
      iw[k] = 0; ia[k] = '0; idat[k] = '0; act[k] = 0;
      m_pend[k] = 0; m_free[k] = 0; m_due[k] = 0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) do_checks(k);
    for (int k = 0; k < 2; k++) rst[k] = 0;

    // Preload every line; line 5 gets the A5 pattern.
    for (int i = 0; i < int'(NL); i++) begin
      for (int k = 0; k < 2; k++) begin
        iw[k]   = 1;
        ia[k]   = DL'(i);
        idat[k] = (i == 5) ? {16{8'hA5}} : rand_line();
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) do_checks(k);
    end
    for (int k = 0; k < 2; k++) iw[k] = 0;

    // Aliased read of line 5 (addr 16+5) first, then random traffic.
    for (int k = 0; k < 2; k++) begin
      rd[k] = 1; ad[k] = ADDR_W'(NL + 5); act[k] = 1;
    end
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) do_checks(k);
      for (int k = 0; k < 2; k++) drive(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
